// File: rtl/mux_arb_pkg.sv
// Shared types and default sizing for the round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int unsigned DEFAULT_N        = 8;
  localparam int unsigned DEFAULT_MAX_HOLD = 16;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/data/grant bundle between requesters and the mux arbiter.
interface mux_rr_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
);
  localparam int unsigned SEL_W = $clog2(N);

  logic [N-1:0]     req;
  logic [N-1:0]     x;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             y;
  logic             timeout;

  modport master (output req, x, input grant, sel, busy, y, timeout);
  modport slave  (input req, x, output grant, sel, busy, y, timeout);
endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [SEL_W-1:0] w_enc;

  // Rotate so ptr lands at bit 0; lowest set bit then wins.
  assign w_dbl = {req, req};
  assign w_rot = N'(w_dbl >> ptr);

  always_comb begin
    w_enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_enc = SEL_W'(i);
    end
  end

  assign found = |req;
  assign idx   = w_enc + ptr;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbitration with hold timeout driving a shared N:1 mux select.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned N        = DEFAULT_N,
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic             clk,
  input  logic             reset_n,
  mux_rr_arbiter_if.slave  bus
);

  localparam int unsigned SEL_W = $clog2(N);
  localparam int unsigned CNT_W = $clog2(MAX_HOLD) + 1;

  arb_state_t       r_state, w_state_nxt;
  logic [N-1:0]     r_grant, w_grant_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic             w_found;
  logic [SEL_W-1:0] w_idx;

  rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
    .req   (bus.req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_sel     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_sel     <= w_sel_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // Release and timeout both go through IDLE, so sel never moves under a grant.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_sel_nxt     = r_sel;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;

    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_grant_nxt = N'(1) << w_idx;
          w_sel_nxt   = w_idx;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (!bus.req[r_sel] || (r_cnt == CNT_W'(MAX_HOLD - 1))) begin
          w_state_nxt   = IDLE;
          w_grant_nxt   = '0;
          w_busy_nxt    = 1'b0;
          w_ptr_nxt     = r_sel + SEL_W'(1);
          w_timeout_nxt = bus.req[r_sel];
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.grant   = r_grant;
  assign bus.sel     = r_sel;
  assign bus.busy    = r_busy;
  assign bus.timeout = r_timeout;
  assign bus.y       = bus.x[r_sel] & r_busy;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized + directed bench for mux_rr_arbiter against an owner/tenure reference model.
module tb_mux_rr_arbiter;

  localparam int unsigned N        = 8;
  localparam int unsigned MAX_HOLD = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.N(N)) bus();

  mux_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Reference: who owns the mux, how many cycles it has held it, where the scan starts.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  int m_sel   = 0;
  bit m_to    = 1'b0;
  int c;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_owner = -1; m_held = 0; m_ptr = 0; m_sel = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < int'(N); k++) begin
          c = (m_ptr + k) % int'(N);
          if (m_owner < 0 && bus.req[c]) begin
            m_owner = c; m_sel = c; m_held = 1;
          end
        end
      end else if (!bus.req[m_owner]) begin
        m_ptr = (m_owner + 1) % int'(N); m_owner = -1;
      end else if (m_held == int'(MAX_HOLD)) begin
        m_ptr = (m_owner + 1) % int'(N); m_owner = -1; m_to = 1'b1;
      end else begin
        m_held++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [N-1:0] e_grant;
    logic         e_busy;
    if (check_en) begin
      e_grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
      e_busy  = (m_owner >= 0);
      chk("grant",   32'(bus.grant),   32'(e_grant));
      chk("busy",    32'(bus.busy),    32'(e_busy));
      chk("sel",     32'(bus.sel),     32'(m_sel));
      chk("timeout", 32'(bus.timeout), 32'(m_to));
      chk("y",       32'(bus.y),       32'(e_busy & bus.x[m_sel]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int rr_exp [4]   = '{7, 0, 2, 7};
  int y_exp  [8]   = '{0, 0, 1, 1, 0, 1, 0, 1};
  logic [N-1:0] r;

  initial begin
    reset_n = 1'b0; bus.req = 8'hFF; bus.x = 8'h00;
    tick(); check_en = 1'b1;
    tick();
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_busy",  32'(bus.busy),  32'h0);
    chk("rst_sel",   32'(bus.sel),   32'h0);
    chk("rst_to",    32'(bus.timeout), 32'h0);
    reset_n = 1'b1; bus.req = '0;
    tick(); tick();
    chk("idle_grant", 32'(bus.grant), 32'h0);

    // Single request, then release
    bus.req = 8'b0000_0100; bus.x = 8'b1010_1100;
    tick();
    chk("single_grant", 32'(bus.grant), 32'h04);
    chk("single_sel",   32'(bus.sel),   32'd2);
    chk("single_y",     32'(bus.y),     32'd1);
    bus.req = '0;
    tick();
    chk("single_rel", 32'(bus.grant), 32'h0);
    chk("single_rel_y", 32'(bus.y), 32'h0);

    // Round-robin order with 2-cycle tenures
    bus.req = 8'b1000_0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_grant", 32'(bus.grant), 32'(8'(1) << rr_exp[i]));
      tick();
      bus.req = 8'b1000_0101 & ~(8'(1) << rr_exp[i]);
      tick();
      chk("rr_bubble", 32'(bus.grant), 32'h0);
      bus.req = 8'b1000_0101;
    end
    bus.req = '0;
    tick();

    // Timeout alternation
    bus.req = 8'b0000_0011;
    for (int t = 0; t < 2; t++) begin
      for (int h = 0; h < int'(MAX_HOLD); h++) begin
        tick();
        chk("to_hold", 32'(bus.grant), 32'(8'(1) << t));
      end
      tick();
      chk("to_bubble", 32'(bus.grant), 32'h0);
      chk("to_pulse",  32'(bus.timeout), 32'h1);
    end
    tick();
    chk("to_back", 32'(bus.grant), 32'h01);
    bus.req = '0;
    tick(); tick();

    // Reset mid-grant
    bus.req = 8'h04;
    tick();
    repeat (5) tick();
    chk("mid_pre", 32'(bus.grant), 32'h04);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_grant", 32'(bus.grant), 32'h0);
    chk("mid_rst_to",    32'(bus.timeout), 32'h0);
    reset_n = 1'b1;
    tick();
    chk("mid_regrant", 32'(bus.grant), 32'h04);
    bus.req = '0;
    tick();

    // Data path sweep
    bus.x = 8'b1010_1100;
    for (int i = 0; i < int'(N); i++) begin
      bus.req = 8'(1) << i;
      tick();
      chk("sweep_y", 32'(bus.y), 32'(y_exp[i]));
      bus.req = '0;
      tick();
      chk("sweep_bubble_y", 32'(bus.y), 32'h0);
    end

    // Randomized traffic with long-lived request patterns
    repeat (3000) begin
      if ($urandom_range(7) == 0) begin
        r = N'($urandom);
        bus.req = ($urandom_range(1) == 0) ? (r & N'($urandom)) : r;
      end
      bus.x   = N'($urandom);
      reset_n = ($urandom_range(255) != 0);
      tick();
    end

    reset_n = 1'b1;
    tick();
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
